// File: rtl/timer_tick_scheduler.sv
// Avalon-MM write master that programs the SOPC interval timer, clears its IRQ on every tick,
// and fans each serviced tick out to NUM_CH periodic countdown channels. One write per cycle, zero wait states assumed.
module timer_tick_scheduler #(
  parameter int          NUM_CH      = 4,
  parameter int          CW          = 16,
  parameter logic [31:0] TICK_PERIOD = 32'd9999
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_arm,
  input  logic [NUM_CH-1:0]    ch_disarm,
  input  logic [NUM_CH*CW-1:0] ch_reload,
  output logic [NUM_CH-1:0]    ch_active,
  output logic [NUM_CH-1:0]    ch_expire,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic                 tmr_irq,
  output logic [31:0]          tick_count,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, SERVICE, WR_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        busy_q, busy_d;
  logic [31:0] tick_count_q, tick_count_d;

  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [CW-1:0]     rld_q [NUM_CH];
  logic [CW-1:0]     rld_d [NUM_CH];
  logic [CW-1:0]     arm_val [NUM_CH];
  logic [NUM_CH-1:0] act_q, act_d;
  logic [NUM_CH-1:0] exp_q, exp_d;

  // RUN checks the irq before enable so a pending tick is never dropped on shutdown.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = WR_PL;
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTL;
      WR_CTL:  state_d = RUN;
      RUN: begin
        if (tmr_irq)      state_d = ACK;
        else if (!enable) state_d = WR_STOP;
      end
      ACK:     state_d = SERVICE;
      SERVICE: state_d = enable ? RUN : WR_STOP;
      WR_STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wdat_d = 16'h0000;
    case (state_d)
      WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdat_d = TICK_PERIOD[15:0];
      end
      WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdat_d = TICK_PERIOD[31:16];
      end
      WR_CTL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdat_d = 16'h0007;
      end
      ACK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wdat_d = 16'h0000;
      end
      WR_STOP: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdat_d = 16'h0008;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE) && (state_d != RUN);
  end

  always_comb begin
    tick_count_d = tick_count_q;
    if (state_d == WR_CTL)
      tick_count_d = 32'd0;
    else if (state_q == SERVICE)
      tick_count_d = tick_count_q + 32'd1;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      arm_val[i] = ch_reload[i*CW +: CW];
      if (arm_val[i] == '0)
        arm_val[i] = CW'(1);
    end
  end

  // Arm beats both disarm and the tick update; expiry reloads from the last armed value.
  always_comb begin
    cnt_d = cnt_q;
    rld_d = rld_q;
    act_d = act_q;
    exp_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_arm[i]) begin
        rld_d[i] = arm_val[i];
        cnt_d[i] = arm_val[i];
        act_d[i] = 1'b1;
      end else if (ch_disarm[i]) begin
        act_d[i] = 1'b0;
      end else if (state_q == SERVICE && act_q[i]) begin
        if (cnt_q[i] == CW'(1)) begin
          exp_d[i] = 1'b1;
          cnt_d[i] = rld_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= 3'd0;
      wdat_q       <= 16'h0000;
      busy_q       <= 1'b0;
      tick_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      busy_q       <= busy_d;
      tick_count_q <= tick_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q <= '0;
      exp_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        rld_q[i] <= '0;
      end
    end else begin
      act_q <= act_d;
      exp_q <= exp_d;
      cnt_q <= cnt_d;
      rld_q <= rld_d;
    end
  end

  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_address    = addr_q;
  assign tmr_writedata  = wdat_q;
  assign busy           = busy_q;
  assign tick_count     = tick_count_q;
  assign ch_active      = act_q;
  assign ch_expire      = exp_q;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler: bus writes are scoreboarded against a queue,
// channel behaviour against a small countdown model.
module tb_timer_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  ch_arm;
  logic [3:0]  ch_disarm;
  logic [63:0] ch_reload;
  logic [3:0]  ch_active;
  logic [3:0]  ch_expire;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic [31:0] tick_count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [18:0] exp_q[$];

  int   m_cnt [4];
  int   m_rld [4];
  logic [3:0] m_act;
  int   m_ticks;

  timer_tick_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .ch_arm         (ch_arm),
    .ch_disarm      (ch_disarm),
    .ch_reload      (ch_reload),
    .ch_active      (ch_active),
    .ch_expire      (ch_expire),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq),
    .tick_count     (tick_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write seen on the bus must be the next one the stimulus queued.
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL bus_unexpected observed=addr%0d/0x%0h expected=no write", tmr_address, tmr_writedata);
      end else begin
        chk("bus_write", {13'd0, tmr_address, tmr_writedata}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic m_arm(input int c);
    int r;
    r = int'(ch_reload[c*16 +: 16]);
    m_rld[c] = (r == 0) ? 1 : r;
    m_cnt[c] = m_rld[c];
    m_act[c] = 1'b1;
  endtask

  task automatic m_tick(input logic [3:0] armm, output logic [3:0] expm);
    expm = 4'b0;
    for (int c = 0; c < 4; c++) begin
      if (armm[c]) begin
        m_arm(c);
      end else if (m_act[c]) begin
        if (m_cnt[c] == 1) begin
          expm[c] = 1'b1;
          m_cnt[c] = m_rld[c];
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
    end
  endtask

  task automatic arm_ch(input int c, input int r, input logic also_disarm);
    ch_reload[c*16 +: 16] = 16'(r);
    ch_arm = 4'b0;
    ch_arm[c] = 1'b1;
    if (also_disarm) ch_disarm[c] = 1'b1;
    step();
    ch_arm = 4'b0;
    ch_disarm = 4'b0;
    m_arm(c);
    chk($sformatf("arm_active_ch%0d", c), {28'd0, ch_active}, {28'd0, m_act});
  endtask

  task automatic disarm_ch(input int c);
    ch_disarm = 4'b0;
    ch_disarm[c] = 1'b1;
    step();
    ch_disarm = 4'b0;
    m_act[c] = 1'b0;
    chk($sformatf("disarm_active_ch%0d", c), {28'd0, ch_active}, {28'd0, m_act});
  endtask

  // One full tick from RUN: raise irq, wait for the clear write, then check the channel update.
  task automatic do_tick(input logic [3:0] armm);
    logic [3:0] expm;
    bit seen;
    seen = 0;
    tmr_irq = 1'b1;
    exp_q.push_back({3'd0, 16'h0000});
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) seen = 1;
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL ack_timeout observed=no addr0 write expected=addr0 write");
    end
    tmr_irq = 1'b0;
    step();
    ch_arm = armm;
    m_tick(armm, expm);
    step();
    ch_arm = 4'b0;
    m_ticks++;
    chk($sformatf("expire_tick%0d", m_ticks), {28'd0, ch_expire}, {28'd0, expm});
    chk($sformatf("active_tick%0d", m_ticks), {28'd0, ch_active}, {28'd0, m_act});
    chk($sformatf("tick_count%0d", m_ticks), tick_count, 32'(m_ticks));
    chk("no_second_ack", {31'd0, tmr_chipselect}, 32'd0);
    step();
    chk($sformatf("expire_width%0d", m_ticks), {28'd0, ch_expire}, 32'd0);
  endtask

  initial begin
    logic [3:0] expm;
    reset = 1'b1; enable = 1'b0; tmr_irq = 1'b0;
    ch_arm = '0; ch_disarm = '0; ch_reload = '0;
    m_act = '0; m_ticks = 0;
    for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_rld[c] = 0; end
    repeat (3) step();
    chk("rst_cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, tmr_write_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ticks", tick_count, 32'd0);
    chk("rst_active", {28'd0, ch_active}, 32'd0);
    reset = 1'b0;
    step();

    // Configuration sequence
    exp_q.push_back({3'd2, 16'h270F});
    exp_q.push_back({3'd3, 16'h0000});
    exp_q.push_back({3'd1, 16'h0007});
    enable = 1'b1;
    step();
    chk("cfg_pl_busy", {31'd0, busy}, 32'd1);
    chk("cfg_pl_addr", {29'd0, tmr_address}, 32'd2);
    step();
    chk("cfg_ph_busy", {31'd0, busy}, 32'd1);
    step();
    chk("cfg_ctl_busy", {31'd0, busy}, 32'd1);
    chk("cfg_ctl_ticks", tick_count, 32'd0);
    step();
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_cs", {31'd0, tmr_chipselect}, 32'd0);

    // Periodic channel 0, reload 3
    arm_ch(0, 3, 1'b0);
    for (int t = 0; t < 9; t++) do_tick(4'b0000);

    // One-shot style channel 1 with reload 0, then disarmed
    arm_ch(1, 0, 1'b0);
    do_tick(4'b0000);
    disarm_ch(1);
    do_tick(4'b0000);
    do_tick(4'b0000);

    // Arm and disarm together on channel 3
    arm_ch(3, 2, 1'b1);

    // Channel 2 about to expire is re-armed with 5 during SERVICE
    arm_ch(2, 1, 1'b0);
    ch_reload[2*16 +: 16] = 16'd5;
    do_tick(4'b0100);
    for (int t = 0; t < 5; t++) do_tick(4'b0000);

    // Shutdown from RUN
    exp_q.push_back({3'd1, 16'h0008});
    enable = 1'b0;
    step();
    chk("stop_busy", {31'd0, busy}, 32'd1);
    chk("stop_data", {16'd0, tmr_writedata}, 32'h8);
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("idle_active", {28'd0, ch_active}, {28'd0, m_act});
    disarm_ch(3);
    arm_ch(1, 4, 1'b0);

    // Enable dropped during configuration with an irq pending
    exp_q.push_back({3'd2, 16'h270F});
    exp_q.push_back({3'd3, 16'h0000});
    exp_q.push_back({3'd1, 16'h0007});
    exp_q.push_back({3'd0, 16'h0000});
    exp_q.push_back({3'd1, 16'h0008});
    enable = 1'b1;
    step();
    enable = 1'b0;
    tmr_irq = 1'b1;
    step();
    step();
    chk("recfg_ticks", tick_count, 32'd0);
    m_ticks = 0;
    step();
    chk("recfg_run_busy", {31'd0, busy}, 32'd0);
    step();
    chk("recfg_ack_addr", {29'd0, tmr_address}, 32'd0);
    chk("recfg_ack_cs", {31'd0, tmr_chipselect}, 32'd1);
    tmr_irq = 1'b0;
    step();
    chk("recfg_service_busy", {31'd0, busy}, 32'd1);
    m_tick(4'b0000, expm);
    m_ticks++;
    step();
    chk("recfg_stop_addr", {29'd0, tmr_address}, 32'd1);
    chk("recfg_expire", {28'd0, ch_expire}, {28'd0, expm});
    chk("recfg_ticks1", tick_count, 32'(m_ticks));
    step();
    chk("recfg_idle_busy", {31'd0, busy}, 32'd0);

    // Reset during WR_PH abandons the write
    exp_q.push_back({3'd2, 16'h270F});
    exp_q.push_back({3'd3, 16'h0000});
    enable = 1'b1;
    step();
    step();
    chk("ph_addr", {29'd0, tmr_address}, 32'd3);
    reset = 1'b1;
    step();
    chk("midrst_cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("midrst_wn", {31'd0, tmr_write_n}, 32'd1);
    chk("midrst_addr", {29'd0, tmr_address}, 32'd0);
    chk("midrst_data", {16'd0, tmr_writedata}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ticks", tick_count, 32'd0);
    chk("midrst_active", {28'd0, ch_active}, 32'd0);
    chk("midrst_expire", {28'd0, ch_expire}, 32'd0);
    enable = 1'b0;
    reset = 1'b0;
    step();
    step();
    chk("final_cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
